// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked single-cycle ALU with iterative shift-add MAC
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   request handshake; opcode, rs1, rs2, rs3 captured at accept
//   opcode                ADD=0 SUB=1 AND=2 OR=3 SLL=4 SRA=5 MAC=6 XOR=7 SRL=8
//                         SLT=9 SLTU=10; 11-15 illegal (rd=0, err=1)
//   rs1, rs2, rs3         operands; rs2 low bits are the shift amount, rs3 the MAC addend
//   out_valid / out_ready result handshake; rd and err held stable until delivered
//   rd, err               registered result and illegal-opcode flag
//   busy                  high while the MAC multiplier is iterating
module alu_pipe #(
  parameter int WIDTH    = 32,
  parameter int MAC_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [WIDTH-1:0] rs3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic             err,
  output logic             busy
);

  localparam int N  = WIDTH / MAC_STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRA  = 4'd5;
  localparam logic [3:0] OP_MAC  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;

  logic             accept;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_rd;
  logic             alu_err;
  logic [WIDTH-1:0] acc_step;

  // In DONE a new request may enter in the same cycle the held result leaves,
  // which is what gives one op per cycle with no bubble.
  assign in_ready = !reset && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign shamt    = rs2[SW-1:0];

  always_comb begin
    alu_rd  = '0;
    alu_err = 1'b0;
    case (opcode)
      OP_ADD:  alu_rd = rs1 + rs2;
      OP_SUB:  alu_rd = rs1 - rs2;
      OP_AND:  alu_rd = rs1 & rs2;
      OP_OR:   alu_rd = rs1 | rs2;
      OP_XOR:  alu_rd = rs1 ^ rs2;
      OP_SLL:  alu_rd = rs1 << shamt;
      OP_SRL:  alu_rd = rs1 >> shamt;
      OP_SRA:  alu_rd = WIDTH'($signed(rs1) >>> shamt);
      OP_SLT:  alu_rd = {{(WIDTH-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      OP_SLTU: alu_rd = {{(WIDTH-1){1'b0}}, (rs1 < rs2)};
      OP_MAC:  alu_rd = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // MAC_STEP multiplier bits per cycle. mcand is pre-shifted and mplier
  // consumed from the bottom, so only the low WIDTH bits of the product are
  // ever formed; rs3 is preloaded into the accumulator at accept.
  always_comb begin
    acc_step = acc;
    for (int i = 0; i < MAC_STEP; i++) begin
      if (mplier[i]) begin
        acc_step = acc_step + (mcand << i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      rd        <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (opcode == OP_MAC) begin
              state     <= S_MUL;
              busy      <= 1'b1;
              out_valid <= 1'b0;
              acc       <= rs3;
              mcand     <= rs1;
              mplier    <= rs2;
              count     <= '0;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              rd        <= alu_rd;
              err       <= alu_err;
            end
          end else if ((state == S_DONE) && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        S_MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << MAC_STEP;
          mplier <= mplier >> MAC_STEP;
          if (count == LAST) begin
            count     <= '0;
            state     <= S_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            rd        <= acc_step;
            err       <= 1'b0;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe
module tb_alu_pipe;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, out_ready;
  logic [3:0] opcode;
  logic [W-1:0] rs1, rs2, rs3;
  logic in_ready, out_valid, err, busy;
  logic [W-1:0] rd;

  logic in_valid4;
  logic out_ready4 = 1'b1;
  logic in_ready4, out_valid4, err4, busy4;
  logic [W-1:0] rd4;

  typedef struct {
    logic [W-1:0] rd;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int stalls = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .MAC_STEP(1)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs1(rs1), .rs2(rs2), .rs3(rs3),
    .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .err(err), .busy(busy)
  );

  alu_pipe #(.WIDTH(W), .MAC_STEP(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .opcode(opcode), .rs1(rs1), .rs2(rs2), .rs3(rs3),
    .out_valid(out_valid4), .out_ready(out_ready4), .rd(rd4), .err(err4), .busy(busy4)
  );

  // Scoreboard: every delivery is compared against the oldest pushed expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL deliver_unexpected rd=%h err=%b with empty scoreboard", rd, err);
      end else begin
        e = sb.pop_front();
        if (rd !== e.rd || err !== e.err) begin
          errors++;
          $display("FAIL result rd=%h err=%b expected rd=%h err=%b", rd, err, e.rd, e.err);
        end
      end
    end
  end

  function automatic exp_t model(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b,
                                 logic [W-1:0] c);
    exp_t e;
    int sh;
    logic [2*W-1:0] p;
    sh = int'(b[4:0]);
    e.err = 1'b0;
    e.rd = '0;
    case (op)
      4'd0:  e.rd = a + b;
      4'd1:  e.rd = a - b;
      4'd2:  e.rd = a & b;
      4'd3:  e.rd = a | b;
      4'd4:  e.rd = a << sh;
      4'd5: begin
        e.rd = a;
        repeat (sh) e.rd = {e.rd[W-1], e.rd[W-1:1]};
      end
      4'd6: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.rd = p[W-1:0] + c;
      end
      4'd7:  e.rd = a ^ b;
      4'd8:  e.rd = a >> sh;
      4'd9:  e.rd = (a[W-1] != b[W-1]) ? {31'd0, a[W-1]} : {31'd0, (a < b)};
      4'd10: e.rd = {31'd0, (a < b)};
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and holds it until accepted; leaves in_valid high so
  // the caller can chain back-to-back requests.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic [W-1:0] erd, input logic eerr,
                      input bit push);
    exp_t e;
    int n;
    in_valid = 1'b1;
    opcode = op;
    rs1 = a;
    rs2 = b;
    rs3 = c;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
      stalls++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
    end else if (push) begin
      e.rd = erd;
      e.err = eerr;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required 0", sb.size());
      sb.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_valid4 = 1'b0;
    out_ready = 1'b1;
    opcode = '0;
    rs1 = '0;
    rs2 = '0;
    rs3 = '0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, err, rd} !== {4'b0000, 32'd0}) begin
      errors++;
      $display("FAIL reset_state in_ready=%b out_valid=%b busy=%b err=%b rd=%h required all 0",
               in_ready, out_valid, busy, err, rd);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready in_ready=%b required 1", in_ready);
    end
    tick();
  endtask

  task automatic test_alu_basic();
    out_ready = 1'b1;
    send(4'd0, 32'd5, 32'd7, 32'd0, 32'd12, 1'b0, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || rd !== 32'd12 || err !== 1'b0) begin
      errors++;
      $display("FAIL add_latency out_valid=%b rd=%h err=%b required 1/0000000c/0",
               out_valid, rd, err);
    end
    tick();
    send(4'd1, 32'd5, 32'd7, 32'd0, 32'hFFFFFFFE, 1'b0, 1'b1);
    send(4'd5, 32'h80000000, 32'h24, 32'd0, 32'hF8000000, 1'b0, 1'b1);
    send(4'd8, 32'h80000000, 32'h24, 32'd0, 32'h08000000, 1'b0, 1'b1);
    send(4'd9, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1, 1'b0, 1'b1);
    send(4'd10, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_mac();
    int bad;
    out_ready = 1'b1;
    send(4'd6, 32'd3, 32'd4, 32'd5, 32'd17, 1'b0, 1'b1);
    in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mac_busy_window bad_cycles=%0d required 0", bad);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mac_latency out_valid=%b busy=%b required 1/0 on cycle 33", out_valid, busy);
    end
    drain();
    send(4'd6, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_mac_step4();
    int bad;
    opcode = 4'd6;
    rs1 = 32'd3;
    rs2 = 32'd4;
    rs3 = 32'd5;
    in_valid4 = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL step4_in_ready in_ready=%b required 1", in_ready4);
    end
    tick();
    in_valid4 = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy4 !== 1'b1 || out_valid4 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL step4_busy_window bad_cycles=%0d required 0", bad);
    end
    @(negedge clk);
    checks++;
    if (out_valid4 !== 1'b1 || rd4 !== 32'd17 || err4 !== 1'b0) begin
      errors++;
      $display("FAIL step4_result out_valid=%b rd=%h err=%b required 1/00000011/0",
               out_valid4, rd4, err4);
    end
    @(negedge clk);
    checks++;
    if (out_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL step4_release out_valid=%b required 0", out_valid4);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int bad;
    out_ready = 1'b0;
    send(4'd0, 32'd1, 32'd1, 32'd0, 32'd2, 1'b0, 1'b1);
    opcode = 4'd0;
    rs1 = 32'd9;
    rs2 = 32'd9;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || rd !== 32'd2 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold bad_cycles=%0d required 0", bad);
    end
    tick();
    out_ready = 1'b1;
    send(4'd0, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || rd !== 32'd4) begin
      errors++;
      $display("FAIL backpressure_no_bubble out_valid=%b rd=%h required 1/00000004",
               out_valid, rd);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [3:0] op;
    logic [W-1:0] a, b;
    out_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd6) op = 4'd7;
      a = $urandom();
      b = $urandom();
      if (i % 4 == 0) b = a;
      e = model(op, a, b, 32'd0);
      send(op, a, b, 32'd0, e.rd, e.err, 1'b1);
    end
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL back_to_back_stalls stalls=%0d required 0", stalls);
    end
    drain();
    for (int i = 0; i < 3; i++) begin
      a = $urandom();
      b = $urandom();
      e = model(4'd6, a, b, 32'h1234);
      send(4'd6, a, b, 32'h1234, e.rd, e.err, 1'b1);
    end
    drain();
  endtask

  task automatic test_reset_abort();
    int seen;
    out_ready = 1'b1;
    send(4'd6, 32'd3, 32'd4, 32'd5, 32'd17, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_ready_during_reset in_ready=%b required 0", in_ready);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || rd !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_state out_valid=%b busy=%b rd=%h in_ready=%b required 0/0/0/1",
               out_valid, busy, rd, in_ready);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_stale_result cycles_valid=%0d required 0", seen);
    end
    tick();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    send(4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || err !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL illegal_flag out_valid=%b err=%b rd=%h required 1/1/00000000",
               out_valid, err, rd);
    end
    tick();
    send(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_mac();
    test_mac_step4();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t required completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the core's combinational ALU.
- Executes ADD/SUB/AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU in one cycle; executes MAC (rs1*rs2+rs3) on an iterative shift-add multiplier.
- Sits between decode/operand-read and writeback; a result is held until writeback accepts it.

Parameters:
- WIDTH, 32: operand/result width; power of two, >= 8.
- MAC_STEP, 1: multiplier bits retired per cycle; must divide WIDTH. MAC iteration count N = WIDTH/MAC_STEP.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request this cycle
- opcode  input  4  operation select
- rs1  input  WIDTH  operand 1
- rs2  input  WIDTH  operand 2 / shift amount
- rs3  input  WIDTH  MAC addend
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- rd  output  WIDTH  result
- err  output  1  illegal opcode flag, qualified by out_valid
- busy  output  1  high while in MUL state

Behaviour:
- Opcode encoding (carried in riscv_define_all.v): ADD=0, SUB=1, AND=2, OR=3, SLL=4, SRA=5, MAC=6, XOR=7, SRL=8, SLT=9, SLTU=10. Codes 11-15 are illegal.
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Deliver occurs when out_valid && out_ready.
  - opcode/rs1/rs2/rs3 are captured at accept; later input changes are ignored.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. Accept of non-MAC (including illegal) -> DONE. Accept of MAC -> MUL.
  - MUL: in_ready=0, busy=1. Step counter runs 0..N-1; each cycle adds MAC_STEP partial products into the accumulator. Leaves for DONE after N cycles; counter wraps to 0.
  - DONE: out_valid=1, rd/err stable. in_ready=out_ready.
    - Deliver without new accept -> IDLE.
    - Deliver with same-cycle accept -> DONE (non-MAC) or MUL (MAC), with no bubble.
    - No deliver: hold DONE indefinitely with rd/err unchanged.
- Latency from the accept edge:
  - Non-MAC: out_valid high 1 cycle later.
  - MAC: out_valid high N+1 cycles later.
  - Peak throughput is 1 non-MAC op per cycle.
- Arithmetic, all results WIDTH bits with carries and overflow discarded:
  - MAC = low WIDTH bits of (rs1*rs2) + rs3; operands are treated as unsigned, which is sign-agnostic in the low half.
  - Shift amount = rs2[log2(WIDTH)-1:0].
  - SRA is arithmetic (sign-fill); SRL is zero-fill.
  - SLT is a signed compare and SLTU an unsigned compare; each gives 1 or 0, zero-extended.
  - Illegal opcode: rd=0, err=1. err=0 for all legal ops.
- Reset (synchronous, active-high):
  - FSM -> IDLE; out_valid=0, rd=0, err=0, busy=0; accumulator and counter cleared.
  - in_ready=0 during the reset cycle, 1 the cycle after.
  - Reset in MUL or DONE aborts the operation; no result is ever delivered for it.
- rd/err are registered outputs, not combinational from inputs. out_valid never drops without a deliver or reset.

Test Plan (WIDTH=32, MAC_STEP=1 unless stated):
- ADD rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, rd=12, err=0. SUB 5-7 -> rd=0xFFFFFFFE.
- SRA rs1=0x80000000, rs2=0x24 (amount 4) -> rd=0xF8000000. SRL with same operands -> rd=0x08000000. SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
- MAC rs1=3, rs2=4, rs3=5 -> busy high 32 cycles, in_ready=0 throughout, out_valid on cycle 33, rd=17. MAC 0xFFFFFFFF*2+1 -> rd=0xFFFFFFFF. MAC_STEP=4 build with rs1=3, rs2=4, rs3=5 -> rd=17 on cycle 9.
- Backpressure: ADD 1+1 with out_ready=0 for 5 cycles -> out_valid stays 1, rd=2 stable, in_ready=0, new in_valid ignored. Then out_ready=1 with in_valid ADD 2+2 -> rd=4 the following cycle with no idle cycle.
- Reset asserted at MUL step 10 of a MAC -> next cycle out_valid=0, busy=0, rd=0, in_ready=1 after reset deasserts; no stale result ever appears.
- Illegal opcode 15 with rs1=rs2=0xFFFFFFFF -> out_valid=1, rd=0, err=1. A following AND of the same operands -> rd=0xFFFFFFFF, err=0.
